adc_spi_responder: RTL and testbench
====================================

// Module: adc_spi_responder
// PURPOSE
//  SPI responder implementing the MCP3004/3008 command/readout protocol: start bit, SGL/DIFF, D2..D0, null bit, 10-bit MSB-first result.
//  Serves per-channel sample values (ch_data) to an external SPI initiator.
//  - Use 1: hardware-in-loop stand-in for the accelerator-pedal ADC.
//  - Use 2: lets an external MCU read motor telemetry (speed, duty) as ADC channels.
//  All pins are oversampled in the clk domain; no logic is clocked by sclk.
// PARAMETERS
//  NUM_CH       8  channel count, 4 or 8; for 4, D2 is ignored (channel = {1'b0,D1,D0})
//  RES          10 result width; bits shifted MSB first
//  SYNC_STAGES  2  synchronizer depth on cs_n, sclk, din
// PORTS
//  clk       in   1           system clock; sclk high/low time must each be >= SYNC_STAGES+3 clk
//  rst_n     in   1           asynchronous, active-low reset
//  cs_n      in   1           SPI chip select from initiator, active low
//  sclk      in   1           SPI clock from initiator (idle low, mode 0,0)
//  din       in   1           SPI data from initiator
//  ch_data   in   NUM_CH*RES  channel i value at [i*RES +: RES]
//  dout      out  1           SPI data to initiator
//  dout_oe   out  1           DOUT drive enable; 0 = hi-Z (pad tristate external)
//  busy      out  1           1 while any frame is in progress (state != IDLE)
//  req_valid out  1           1-clk pulse when a command is complete and the sample is latched
//  req_sgl   out  1           SGL/DIFF bit of last command; valid with req_valid, held after
//  req_ch    out  3           {D2,D1,D0} of last command; valid with req_valid, held after
// BEHAVIOUR
//  Reset: state IDLE; dout=0, dout_oe=0, busy=0, req_valid=0, req_sgl=0, req_ch=0; sync regs=1 for cs_n, 0 for sclk/din.
//  Edges: rise/fall of sclk from synced history; action happens the clk after detection.
//  - Pin-to-dout latency on a falling edge: SYNC_STAGES+1 clk.
//  States and transitions:
//  - IDLE: go to WAIT_START when synced cs_n goes low.
//  - WAIT_START: each sclk rise with din=1 -> CMD (bit_cnt=0); din=0 rises are leading zeros, ignored, unlimited count.
//  - CMD: 4 sclk rises capture SGL, D2, D1, D0.
//    - On the 4th rise: latch sample, pulse req_valid, update req_sgl/req_ch, go to NULL.
//  - NULL: next sclk fall -> dout=0, dout_oe=1, go to DATA (bit_cnt=RES-1).
//  - DATA: each sclk fall drives sample[bit_cnt] and decrements; the fall after B0 is driven -> TAIL.
//  - TAIL: each further fall drives dout=0; no LSB-first repeat.
//  Sample latch:
//  - SGL=1: sample = ch_data[ch].
//  - SGL=0: sample = ch[{D2,D1,D0}] - ch[{D2,D1,~D0}] when positive, else 0 (no wrap).
//  - ch_data changes after the latch do not affect the frame in progress.
//  cs_n high (synced) in any state: next clk go to IDLE, dout_oe=0, dout=0, bit_cnt cleared.
//  - Abort before the 4th CMD rise: no req_valid.
//  - Abort after: req_* hold their values.
//  cs_n low while sclk is high: that high level is not a rise; only a subsequent 0->1 counts.
//  Simultaneous cs_n rise and sclk edge in the same clk: the cs_n rise wins and the edge is discarded.
//  rst_n low mid-frame: all outputs to reset values immediately (async); frame lost.
// STRUCTURE
//  adc_spi_pkg:
//  - state enum: IDLE, WAIT_START, CMD, NULL_BIT, DATA, TAIL.
//  - localparams: ADC_RES=10, CMD_BITS=4.
//  - function diff_clamp(a,b).
//  Sub-module pin_sync_edge (per input): SYNC_STAGES flops plus a history flop.
//  - Outputs level, rise, fall.
//  - Reset value parameterised: 1 for cs_n, 0 for sclk/din.
//  Main FSM, bit counter and sample register live in adc_spi_responder.
// TESTING
//  1 SGL read:
//  - Stimulus: ch_data ch1=10'h2A5; frame with 7 leading zeros, then 1,1,0,0,1.
//  - Response: req_valid once with req_sgl=1, req_ch=1; null 0, then dout bits 1010100101.
//  2 DIFF read:
//  - Stimulus: ch2=600, ch3=250; cmd SGL=0, D=010.
//  - Response: result 350 (10'h15E).
//  - Swap to D=011: result 0 (clamped, no wrap).
//  3 Abort:
//  - Stimulus: cs_n high after the 2nd CMD rise.
//  - Response: no req_valid, dout_oe=0 within SYNC_STAGES+2 clk, busy=0.
//  - Then a full ch0 frame reads back correctly.
//  4 Tail and latch:
//  - Stimulus: 20 falls after D0; ch_data changed after the latch.
//  - Response: bits B9..B0 from the latched value, then 0s; dout_oe=1 until cs_n high.
//  5 NUM_CH=4: cmd D=111 -> returns ch3; req_ch reports 3'b111.
//  6 Reset mid-DATA:
//  - Stimulus: rst_n low at bit B5.
//  - Response: dout_oe=0 and busy=0 immediately, no clk needed.
//  - Next frame after release is correct.

Source files
------------

// File: rtl/adc_spi_pkg.sv
// Shared types and helpers for the MCP3004/3008-style SPI responder.
//   state_e     : responder frame state
//   ADC_RES     : nominal result width
//   CMD_BITS    : command bits after the start bit (SGL, D2, D1, D0)
//   diff_clamp  : a - b when a > b, else 0 (pseudo-differential result, no wrap)
package adc_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    CMD,
    NULL_BIT,
    DATA,
    TAIL
  } state_e;

  localparam int unsigned ADC_RES  = 10;
  localparam int unsigned CMD_BITS = 4;

  function automatic int unsigned diff_clamp(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : 0;
  endfunction

endpackage

// File: rtl/pin_sync_edge.sv
// Input pin synchronizer with edge detection.
//   clk, rst_n : system clock, async active-low reset
//   pin        : asynchronous input pin
//   level      : synchronized level
//   rise, fall : one-clk pulses derived from the synchronized history
// RST_VAL sets the reset value of every stage (idle level of the pin).
module pin_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = STAGES'({sync_q, pin});
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  always_comb begin
    level = sync_q[STAGES-1];
    rise  = sync_q[STAGES-1] & ~hist_q;
    fall  = ~sync_q[STAGES-1] & hist_q;
  end

endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder emulating the MCP3004/3008 command/readout protocol.
// All SPI pins are oversampled in the clk domain.
//   clk, rst_n      : system clock, async active-low reset
//   cs_n, sclk, din : SPI pins from the initiator (mode 0,0)
//   ch_data         : channel i value at [i*RES +: RES]
//   dout, dout_oe   : SPI data to initiator and its pad drive enable
//   busy            : frame in progress
//   req_valid       : one-clk pulse when the command completes and the sample is latched
//   req_sgl, req_ch : SGL/DIFF and {D2,D1,D0} of the last completed command
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned RES         = ADC_RES,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_n,
  input  logic                  sclk,
  input  logic                  din,
  input  logic [NUM_CH*RES-1:0] ch_data,
  output logic                  dout,
  output logic                  dout_oe,
  output logic                  busy,
  output logic                  req_valid,
  output logic                  req_sgl,
  output logic [2:0]            req_ch
);

  localparam int unsigned CNT_W = $clog2((RES > CMD_BITS) ? RES : CMD_BITS);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic din_lvl, din_rise, din_fall;

  pin_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .pin(cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  pin_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .pin(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  pin_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din_sync (
    .clk(clk), .rst_n(rst_n), .pin(din),
    .level(din_lvl), .rise(din_rise), .fall(din_fall)
  );

  // Only levels of cs_n/din and edges of sclk drive the protocol.
  logic unused_edges;
  assign unused_edges = ^{cs_rise, cs_fall, sclk_lvl, din_rise, din_fall};

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CMD_BITS-1:0]  cmd_q, cmd_d;
  logic [RES-1:0]       sample_q, sample_d;
  logic                 dout_q, dout_d;
  logic                 dout_oe_q, dout_oe_d;
  logic                 req_valid_q, req_valid_d;
  logic                 req_sgl_q, req_sgl_d;
  logic [2:0]           req_ch_q, req_ch_d;

  // Channel selection for the command completing on this rise.
  logic [CMD_BITS-1:0]  cmd_full;
  logic [2:0]           ch_sel, ch_pair;
  logic [RES-1:0]       val_a, val_b;

  always_comb begin
    cmd_full = {cmd_q[CMD_BITS-2:0], din_lvl};
    ch_sel   = (NUM_CH == 4) ? {1'b0, cmd_full[1:0]} : cmd_full[2:0];
    ch_pair  = ch_sel ^ 3'b001;
    val_a    = ch_data[int'(ch_sel) * RES +: RES];
    val_b    = ch_data[int'(ch_pair) * RES +: RES];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      cmd_q       <= '0;
      sample_q    <= '0;
      dout_q      <= 1'b0;
      dout_oe_q   <= 1'b0;
      req_valid_q <= 1'b0;
      req_sgl_q   <= 1'b0;
      req_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_q       <= cmd_d;
      sample_q    <= sample_d;
      dout_q      <= dout_d;
      dout_oe_q   <= dout_oe_d;
      req_valid_q <= req_valid_d;
      req_sgl_q   <= req_sgl_d;
      req_ch_q    <= req_ch_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_d       = cmd_q;
    sample_d    = sample_q;
    dout_d      = dout_q;
    dout_oe_d   = dout_oe_q;
    req_valid_d = 1'b0;
    req_sgl_d   = req_sgl_q;
    req_ch_d    = req_ch_q;

    // Deselect overrides everything, including an sclk edge seen in the same clk.
    if (cs_lvl) begin
      state_d   = IDLE;
      dout_d    = 1'b0;
      dout_oe_d = 1'b0;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = WAIT_START;
        WAIT_START: begin
          if (sclk_rise && din_lvl) begin
            state_d   = CMD;
            bit_cnt_d = '0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            cmd_d = cmd_full;
            if (bit_cnt_q == CNT_W'(CMD_BITS - 1)) begin
              state_d     = NULL_BIT;
              req_valid_d = 1'b1;
              req_sgl_d   = cmd_full[3];
              req_ch_d    = cmd_full[2:0];
              sample_d    = cmd_full[3] ? val_a
                                        : RES'(diff_clamp(32'(val_a), 32'(val_b)));
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        NULL_BIT: begin
          if (sclk_fall) begin
            state_d   = DATA;
            dout_d    = 1'b0;
            dout_oe_d = 1'b1;
            bit_cnt_d = CNT_W'(RES - 1);
          end
        end
        DATA: begin
          if (sclk_fall) begin
            dout_d = sample_q[bit_cnt_q];
            if (bit_cnt_q == '0) state_d = TAIL;
            else                 bit_cnt_d = bit_cnt_q - CNT_W'(1);
          end
        end
        TAIL: begin
          if (sclk_fall) dout_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    dout      = dout_q;
    dout_oe   = dout_oe_q;
    req_valid = req_valid_q;
    req_sgl   = req_sgl_q;
    req_ch    = req_ch_q;
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
module tb_adc_spi_responder;

  localparam int unsigned RES  = 10;
  localparam int unsigned HALF = 8;

  logic clk = 1'b0;
  logic rst_n, cs_n, sclk, din;
  logic [8*RES-1:0] ch8;
  logic [4*RES-1:0] ch4;

  logic dout8, oe8_o, busy8, rv8_o, sgl8;
  logic [2:0] chn8;
  logic dout4, oe4_o, busy4, rv4_o, sgl4;
  logic [2:0] chn4;

  adc_spi_responder #(.NUM_CH(8), .RES(RES), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sclk(sclk), .din(din), .ch_data(ch8),
    .dout(dout8), .dout_oe(oe8_o), .busy(busy8), .req_valid(rv8_o),
    .req_sgl(sgl8), .req_ch(chn8)
  );

  adc_spi_responder #(.NUM_CH(4), .RES(RES), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sclk(sclk), .din(din), .ch_data(ch4),
    .dout(dout4), .dout_oe(oe4_o), .busy(busy4), .req_valid(rv4_o),
    .req_sgl(sgl4), .req_ch(chn4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int rv8 = 0;
  int rv4 = 0;

  always @(negedge clk) begin
    if (rv8_o === 1'b1) rv8 = rv8 + 1;
    if (rv4_o === 1'b1) rv4 = rv4 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic o8, o4, oe8;

  // One SPI bit: din set during low phase, dout sampled just before the rise.
  task automatic xfer(input logic b);
    din = b;
    repeat (HALF) @(negedge clk);
    o8  = dout8;
    o4  = dout4;
    oe8 = oe8_o;
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_cmd(input int lead, input logic sgl, input logic [2:0] ch);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < lead; i++) xfer(1'b0);
    xfer(1'b1);
    xfer(sgl);
    xfer(ch[2]);
    xfer(ch[1]);
    xfer(ch[0]);
  endtask

  task automatic read_res(input int tail, output logic [9:0] r8, output logic [9:0] r4,
                          output logic nul, output logic tl, output logic oe_all);
    xfer(1'b0);
    nul    = o8;
    oe_all = oe8;
    r8     = '0;
    r4     = '0;
    for (int i = 0; i < 10; i++) begin
      xfer(1'b0);
      r8[9-i] = o8;
      r4[9-i] = o4;
      oe_all  = oe_all & oe8;
    end
    tl = 1'b0;
    for (int i = 0; i < tail; i++) begin
      xfer(1'b0);
      tl     = tl | o8;
      oe_all = oe_all & oe8;
    end
  endtask

  task automatic end_frame;
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  logic [9:0] r8, r4;
  logic nul, tl, oe_all;
  int base;

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; din = 1'b0;
    ch8 = '0; ch4 = '0;
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(dout8), 0);
    chk("rst_oe", 32'(oe8_o), 0);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_req_valid", 32'(rv8_o), 0);
    chk("rst_req_sgl", 32'(sgl8), 0);
    chk("rst_req_ch", 32'(chn8), 0);
    chk("rst_oe4", 32'(oe4_o), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", 32'(busy8), 0);

    // 1: single-ended read of ch1 with 7 leading zeros
    ch8[1*RES +: RES] = 10'h2A5;
    base = rv8;
    send_cmd(7, 1'b1, 3'b001);
    chk("t1_rv_count", 32'(rv8 - base), 1);
    chk("t1_req_sgl", 32'(sgl8), 1);
    chk("t1_req_ch", 32'(chn8), 1);
    chk("t1_busy", 32'(busy8), 1);
    read_res(2, r8, r4, nul, tl, oe_all);
    chk("t1_null", 32'(nul), 0);
    chk("t1_result", 32'(r8), 32'h2A5);
    chk("t1_oe", 32'(oe_all), 1);
    end_frame;
    chk("t1_end_busy", 32'(busy8), 0);
    chk("t1_end_oe", 32'(oe8_o), 0);

    // 2: differential reads, positive and clamped
    ch8[2*RES +: RES] = 10'd600;
    ch8[3*RES +: RES] = 10'd250;
    send_cmd(0, 1'b0, 3'b010);
    chk("t2_req_sgl", 32'(sgl8), 0);
    chk("t2_req_ch", 32'(chn8), 2);
    read_res(0, r8, r4, nul, tl, oe_all);
    chk("t2_diff_pos", 32'(r8), 32'h15E);
    end_frame;
    send_cmd(0, 1'b0, 3'b011);
    read_res(0, r8, r4, nul, tl, oe_all);
    chk("t2_diff_clamp", 32'(r8), 0);
    end_frame;

    // 3: abort after the 2nd command rise
    base = rv8;
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    xfer(1'b1);
    xfer(1'b0);
    xfer(1'b0);
    chk("t3_busy_mid", 32'(busy8), 1);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t3_abort_oe", 32'(oe8_o), 0);
    chk("t3_abort_busy", 32'(busy8), 0);
    chk("t3_no_rv", 32'(rv8 - base), 0);
    chk("t3_req_ch_hold", 32'(chn8), 3);
    repeat (6) @(negedge clk);
    ch8[0*RES +: RES] = 10'h1C3;
    send_cmd(3, 1'b1, 3'b000);
    read_res(0, r8, r4, nul, tl, oe_all);
    chk("t3_after_abort", 32'(r8), 32'h1C3);
    end_frame;

    // 4: long tail, ch_data changed after latch
    ch8[4*RES +: RES] = 10'h0F0;
    send_cmd(1, 1'b1, 3'b100);
    ch8[4*RES +: RES] = 10'h30F;
    read_res(20, r8, r4, nul, tl, oe_all);
    chk("t4_latched", 32'(r8), 32'h0F0);
    chk("t4_tail_zero", 32'(tl), 0);
    chk("t4_oe_held", 32'(oe_all), 1);
    chk("t4_oe_before_cs", 32'(oe8_o), 1);
    end_frame;
    chk("t4_oe_after_cs", 32'(oe8_o), 0);

    // 5: 4-channel variant ignores D2
    ch4[3*RES +: RES] = 10'h1E7;
    ch8[7*RES +: RES] = 10'h155;
    base = rv4;
    send_cmd(2, 1'b1, 3'b111);
    chk("t5_rv4_count", 32'(rv4 - base), 1);
    chk("t5_req_ch4", 32'(chn4), 7);
    chk("t5_req_sgl4", 32'(sgl4), 1);
    read_res(0, r8, r4, nul, tl, oe_all);
    chk("t5_result4", 32'(r4), 32'h1E7);
    chk("t5_result8", 32'(r8), 32'h155);
    end_frame;
    chk("t5_busy4", 32'(busy4), 0);

    // 6: async reset in the middle of DATA
    send_cmd(0, 1'b1, 3'b001);
    for (int i = 0; i < 5; i++) xfer(1'b0);
    @(negedge clk);
    chk("t6_oe_pre_reset", 32'(oe8_o), 1);
    chk("t6_busy_pre_reset", 32'(busy8), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_oe", 32'(oe8_o), 0);
    chk("t6_reset_busy", 32'(busy8), 0);
    chk("t6_reset_req_ch", 32'(chn8), 0);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_cmd(0, 1'b1, 3'b001);
    read_res(0, r8, r4, nul, tl, oe_all);
    chk("t6_after_reset", 32'(r8), 32'h2A5);
    end_frame;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
